// File: rtl/adel_imem_loader_if.sv
// Byte-stream handshake between the program source and the adel instruction loader.
// A byte moves on a rising clock edge where byte_valid and byte_ready are both high.
interface adel_imem_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/adel_imem_loader.sv
// adel_imem_loader: loads a length-prefixed program (header byte, then hi/lo byte pairs)
// into a 256 x 16 instruction store. Holds the core in reset until the program is complete,
// then serves inst = mem[pc] combinationally.
// Optional feature macro: ADEL_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte;
// a bad checksum raises the sticky err flag and leaves the core in reset.
module adel_imem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int IW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    adel_imem_loader_if.slave   bus,
    input  logic [AW-1:0]       pc,
    output logic [IW-1:0]       inst,
    output logic                core_nrst,
    output logic                load_done,
    output logic                err
);

    // len needs one extra bit so that a header of 0 can represent a full DEPTH-word program.
    localparam int LW = AW + 1;

`ifdef ADEL_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_HI, S_LO, S_CK, S_RUN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_HI, S_LO, S_RUN} state_t;
`endif

    state_t         state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [7:0]     hi_q, hi_d;
    logic           ready;
    logic           accept;
    logic           wr_en;
    logic [IW-1:0]  wr_data;
    logic [IW-1:0]  mem [DEPTH];

`ifdef ADEL_LOADER_CHECKSUM_EN
    logic [7:0]     csum_q, csum_d;
    logic           err_q, err_d;
`endif

    // Handshake: ready only while a byte is expected and no restart is being requested.
    always_comb begin
        ready = 1'b0;
        case (state_q)
`ifdef ADEL_LOADER_CHECKSUM_EN
            S_HDR, S_HI, S_LO, S_CK: ready = !load_start;
`else
            S_HDR, S_HI, S_LO:       ready = !load_start;
`endif
            default:                 ready = 1'b0;
        endcase
    end

    assign bus.byte_ready = ready;
    assign accept         = ready && bus.byte_valid;

    // Next-state logic: load_start restarts from any state; otherwise each accepted byte advances the FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        wr_en   = 1'b0;
        wr_data = {hi_q, bus.byte_data};
`ifdef ADEL_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
        if (accept) csum_d = csum_q ^ bus.byte_data;
`endif
        if (load_start) begin
            state_d = S_HDR;
`ifdef ADEL_LOADER_CHECKSUM_EN
            csum_d  = 8'h00;
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                S_HDR: if (accept) begin
                    len_d   = (bus.byte_data == 8'h00) ? LW'(DEPTH) : LW'(bus.byte_data);
                    addr_d  = '0;
                    state_d = S_HI;
                end
                S_HI: if (accept) begin
                    hi_d    = bus.byte_data;
                    state_d = S_LO;
                end
                S_LO: if (accept) begin
                    wr_en  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_d == len_q[AW-1:0]) begin
`ifdef ADEL_LOADER_CHECKSUM_EN
                        state_d = S_CK;
`else
                        state_d = S_RUN;
`endif
                    end else begin
                        state_d = S_HI;
                    end
                end
`ifdef ADEL_LOADER_CHECKSUM_EN
                S_CK: if (accept) begin
                    if (bus.byte_data == csum_q) begin
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        len_d   = '0;
                        state_d = S_IDLE;
                    end
                end
`endif
                S_IDLE, S_RUN: state_d = state_q;
                default:       state_d = S_IDLE;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            hi_q    <= '0;
`ifdef ADEL_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
`ifdef ADEL_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    // Instruction store write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; words at or beyond len are masked on the fetch side instead.
        if (wr_en) mem[addr_q] <= wr_data;
    end

    // Fetch port: only words inside the loaded program are visible, and only while running.
    always_comb begin
        inst = '0;
        if (state_q == S_RUN && LW'(pc) < len_q) inst = mem[pc];
    end

    assign core_nrst = (state_q == S_RUN);
    assign load_done = (state_q == S_RUN);
`ifdef ADEL_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adel_imem_loader.sv
// Self-checking bench for adel_imem_loader: randomized program loads checked through
// a scoreboard against a word-level program model (array + length + phase).
module tb_adel_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  pc;
    logic [15:0] inst;
    logic        core_nrst;
    logic        load_done;
    logic        err;

    adel_imem_loader_if bif ();

    adel_imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .bus        (bif.slave),
        .pc         (pc),
        .inst       (inst),
        .core_nrst  (core_nrst),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what program is loaded and which phase the loader is in.
    typedef enum {M_IDLE, M_LOAD, M_RUN} mphase_t;
    logic [15:0] m_mem [256];
    int          m_len;
    mphase_t     m_phase;
    bit          m_err;

    typedef struct packed {
        logic [15:0] inst;
        logic        nrst;
        logic        done;
        logic        err;
        logic        ready;
    } exp_t;

    exp_t        probe_q [$];
    logic [7:0]  byte_q  [$];
    logic        probe_req = 1'b0;
    exp_t        mon_e;

    function automatic exp_t model_expect(input logic [7:0] a);
        exp_t e;
        e.inst  = (m_phase == M_RUN && int'(a) < m_len) ? m_mem[a] : 16'h0000;
        e.nrst  = (m_phase == M_RUN);
        e.done  = (m_phase == M_RUN);
        e.err   = m_err;
        e.ready = (m_phase == M_LOAD);
        return e;
    endfunction

    // Output monitor: compares fetch/status outputs whenever a probe is posted.
    always @(negedge clk) begin
        if (probe_req) begin
            if (probe_q.size() == 0) begin
                check("probe_queue_empty", 1, 0);
            end else begin
                mon_e = probe_q.pop_front();
                check("inst",       inst,           mon_e.inst);
                check("core_nrst",  core_nrst,      mon_e.nrst);
                check("load_done",  load_done,      mon_e.done);
                check("err",        err,            mon_e.err);
                check("byte_ready", bif.byte_ready, mon_e.ready);
            end
        end
    end

    // Handshake monitor: every transfer must be a byte the driver expected to move.
    always @(posedge clk) begin
        if (bif.byte_valid && bif.byte_ready) begin
            if (byte_q.size() == 0) check("unexpected_accept", 1, 0);
            else                    check("byte_data", bif.byte_data, byte_q.pop_front());
        end
    end

    task automatic probe(input logic [7:0] a);
        pc = a;
        probe_q.push_back(model_expect(a));
        probe_req = 1'b1;
        @(posedge clk); #1;
        probe_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit r;
        bit ok = 0;
        int g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
        repeat (g) begin
            bif.byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_q.push_back(b);
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r = bif.byte_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1; break; end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            void'(byte_q.pop_back());
        end
        bif.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        m_phase = M_LOAD;
        m_err   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_phase = M_IDLE;
        m_err   = 1'b0;
        m_len   = 0;
    endtask

    task automatic do_load(input logic [7:0] hdr, input logic [15:0] words [$], input int gap);
        int n = (hdr == 8'h00) ? 256 : int'(hdr);
        logic [7:0] x = hdr;
        pulse_start();
        send_byte(hdr, gap);
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8], gap);
            send_byte(words[i][7:0], gap);
            x = x ^ words[i][15:8] ^ words[i][7:0];
        end
`ifdef ADEL_LOADER_CHECKSUM_EN
        send_byte(x, gap);
`endif
        for (int i = 0; i < n; i++) m_mem[i] = words[i];
        m_len   = n;
        m_phase = M_RUN;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w [$];
        int n;

        rst = 1'b1; load_start = 1'b0; pc = 8'h00;
        bif.byte_valid = 1'b0; bif.byte_data = 8'h00;
        m_phase = M_IDLE; m_err = 1'b0; m_len = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        for (int i = 0; i < 4; i++) probe(8'(i));

        // Two-word program, back-to-back bytes; first probe lands in the first RUN cycle.
        w = '{16'h1234, 16'h5678};
        do_load(8'h02, w, 0);
        probe(8'h00); probe(8'h01); probe(8'h02);

        // Same program with byte_valid toggled every other cycle.
        do_load(8'h02, w, 1);
        probe(8'h00); probe(8'h01); probe(8'h02);

        // Restart while running holds the core in reset from the next cycle.
        pulse_start();
        probe(8'h00);

        // Full 256-word program (header 0): word i = {i, ~i}.
        w.delete();
        for (int i = 0; i < 256; i++) w.push_back({8'(i), ~8'(i)});
        do_load(8'h00, w, 0);
        probe(8'hFF); probe(8'h00); probe(8'h80); probe(8'($urandom));

        // Abort after three bytes; restart concurrent with byte_valid must not accept the byte.
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        load_start = 1'b1; bif.byte_valid = 1'b1; bif.byte_data = 8'hEE;
        @(negedge clk);
        check("ready_during_start", bif.byte_ready, 0);
        @(posedge clk); #1;
        load_start = 1'b0; bif.byte_valid = 1'b0;
        m_phase = M_LOAD;
        w = '{16'hA5A5};
        do_load(8'h01, w, 0);
        probe(8'h00); probe(8'h01);

        // Reset in the middle of a load abandons it.
        pulse_start();
        send_byte(8'h04, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        do_reset();
        probe(8'h00);
        w = '{16'($urandom), 16'($urandom)};
        do_load(8'h02, w, 0);
        probe(8'h00); probe(8'h01); probe(8'h02);

`ifdef ADEL_LOADER_CHECKSUM_EN
        // Bad checksum: 01 ^ 12 ^ 34 = 27, 00 is sent instead.
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h00, 0);
        m_phase = M_IDLE; m_err = 1'b1; m_len = 0;
        probe(8'h00); probe(8'h01);
        pulse_start();
        probe(8'h00);
`endif

        // Randomized short programs with random gaps, probed inside and past the end.
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(8, 1);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            do_load(8'(n), w, -1);
            for (int i = 0; i <= n; i++) probe(8'(i));
            probe(8'($urandom));
        end

        repeat (3) @(posedge clk);
        check("probe_q_drained", probe_q.size(), 0);
        check("byte_q_drained",  byte_q.size(),  0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adel_imem_loader.md
# adel_imem_loader

Instruction-memory loader and fetch port for the adel core. Receives a program as a byte stream over a valid/ready handshake and writes it into a 256 x 16-bit instruction store. Once the program is loaded, it serves `inst` combinationally from the core's `pc`. The block holds the core in reset through its `core_nrst` output until a complete, valid program has been loaded.

## Interface
- `DEPTH`, 256: instruction words; `pc` wraps at DEPTH.
- `AW`, 8: address width; must equal the core `pc` width.
- `IW`, 16: instruction width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  one-cycle pulse; begins (or restarts) a load.
- `byte_valid`  in  1  upstream byte present.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `pc`  in  AW  fetch address from the core.
- `inst`  out  IW  instruction at `pc`.
- `core_nrst`  out  1  active-low reset to the core.
- `load_done`  out  1  high while a loaded program is running.
- `err`  out  1  sticky error flag; cleared by `load_start` or `rst`.

## Operation
- Transfer rule: a byte moves only when `byte_valid && byte_ready`.
- `byte_ready` is high only in HDR, HI, LO and CK, and only while `load_start` is 0.
- States: IDLE, HDR, HI, LO, CK, RUN.
- IDLE: waits for `load_start`.
  - `load_start` moves to HDR from any state, aborting any load or run in progress.
  - `load_start` also clears `err`.
- HDR: the accepted byte sets `len`.
  - Byte value 0 means 256 words; any other value means that many words.
  - Clears `addr` to 0, then goes to HI.
- HI: the accepted byte is latched as the upper instruction byte; goes to LO.
- LO: the accepted byte is the lower instruction byte.
  - Writes `mem[addr] <= {hi, byte}` and increments `addr` (8-bit, wraps).
  - If `addr+1 == len` (mod 256), goes to CK when the checksum feature is compiled in, otherwise to RUN.
  - Otherwise returns to HI.
- CK: see Configuration.
- RUN: `core_nrst=1` and `load_done=1`.
- `core_nrst=0` in every state other than RUN.
- Fetch: `inst = mem[pc]` combinationally when `pc < len`, or always when `len=256`.
  - For `pc >= len`, `inst = 16'h0000`.
  - Outside RUN, `inst = 16'h0000`.
- Memory is not cleared by reset. Words at or beyond `len` are masked, never read.
- Running checksum: 8-bit XOR of every accepted byte after `load_start`, header included. It is reset to 0 on `load_start`.

## Timing
- Reset values: state IDLE, `core_nrst=0`, `load_done=0`, `err=0`, `byte_ready=0`, `inst=0`, `len=0`, `addr=0`.
- `load_start` sampled at edge t: HDR from t+1, `byte_ready=1` from t+1.
- One byte is accepted per cycle maximum. The FSM never stalls, so back-to-back bytes are accepted every cycle.
- Memory write occurs at the edge on which the LO byte is accepted. That word is fetchable in the first RUN cycle.
- Final byte accepted at edge t: RUN from t+1, with `core_nrst`, `load_done` and fetch all valid in the same cycle t+1.
- `load_start` concurrent with `byte_valid`: the restart wins and the byte is not accepted (`byte_ready=0`).
- `rst` mid-load: the partial program is abandoned and `len=0`. The next load must restart from the header.
- `load_start` during RUN: `core_nrst` falls at t+1 and the core is held until the new load completes.

## Configuration
- `ADEL_LOADER_CHECKSUM_EN` defined:
  - After the last LO byte, the FSM enters CK and accepts one checksum byte.
  - If the byte equals the running XOR of all prior bytes: RUN at the next edge.
  - On mismatch: `err=1`, return to IDLE, `len=0`; the core stays in reset.
- `ADEL_LOADER_CHECKSUM_EN` undefined:
  - The CK state and the XOR register are absent.
  - The last LO byte goes directly to RUN and `err` is tied to 0.

## Test plan
- Reset, then `pc=0..3`: `inst=0000`, `core_nrst=0`, `load_done=0`, `byte_ready=0`.
- `load_start`, then bytes 02, 12, 34, 56, 78 (plus checksum 0x0A if enabled), back-to-back:
  - RUN one cycle after the last byte.
  - `pc=0` gives 1234, `pc=1` gives 5678, `pc=2` gives 0000.
- Same load with `byte_valid` toggled every other cycle: identical memory contents, and no byte is accepted while `byte_valid=0`.
- Header 00 followed by 512 bytes (word i = {i, ~i}): `pc=FF` gives FF00 and RUN is entered.
- Abort: `load_start` after 3 bytes, then a fresh 1-word load A5A5: `pc=0` gives A5A5 and `pc=1` gives 0000.
- (Checksum enabled) Header 01, bytes 12, 34, checksum 00 (expected 27): `err=1`, IDLE, `core_nrst=0`. A following `load_start` clears `err`.
